// File: rtl/psram_pkg.sv
// Shared types and constants for the PSRAM burst controller.
// The state enum is also visible on the controller's debug port.
package psram_pkg;

    localparam int NATIVE_BURST_DEF = 16;
    localparam int CMD_GAP_DEF      = 20;

    localparam logic PSRAM_CMD_RD = 1'b0;
    localparam logic PSRAM_CMD_WR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_CMD   = 3'd2,
        ST_WDATA = 3'd3,
        ST_RWAIT = 3'd4,
        ST_NEXT  = 3'd5,
        ST_DONE  = 3'd6
    } psram_state_e;

endpackage

// File: rtl/psram_cmd_gap_timer.sv
// Loadable down-counter enforcing the minimum spacing between IP commands.
// Runs independently of the controller state and parks at zero.
module psram_cmd_gap_timer #(
    parameter int WIDTH = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/psram_burst_ctrl.sv
// Responder for PSRAM burst requests: splits each burst into fixed-size
// native IP commands and streams words between the IP and the MCU paths.
module psram_burst_ctrl
    import psram_pkg::*;
#(
    parameter int NATIVE_BURST = NATIVE_BURST_DEF,
    parameter int CMD_GAP      = CMD_GAP_DEF,
    parameter int IP_ADDR_W    = 21
) (
    input  logic                 xClk,
    input  logic                 xResetN,
    input  logic                 xPsramReqRead,
    input  logic                 xPsramReqWrite,
    input  logic [31:0]          xMemAddress,
    input  logic [10:0]          xBurstLength,
    output logic                 xPsramReady,
    output logic                 xPsramDone,
    input  logic [31:0]          xWrData,
    input  logic [11:0]          xWrCount,
    output logic                 xWrReady,
    output logic [31:0]          xRdData,
    output logic                 xRdValid,
    output logic                 xIpCmdEn,
    output logic                 xIpCmd,
    output logic [IP_ADDR_W-1:0] xIpAddr,
    output logic [31:0]          xIpWrData,
    output logic [3:0]           xIpDataMask,
    input  logic [31:0]          xIpRdData,
    input  logic                 xIpRdValid,
    input  logic                 xIpCalibDone,
    output logic [2:0]           xDbgState
);

    localparam int BEAT_W = $clog2(NATIVE_BURST) + 1;
    localparam int GAP_W  = $clog2(CMD_GAP) + 1;

    localparam logic [11:0]          NB12      = 12'(NATIVE_BURST);
    localparam logic [GAP_W-1:0]     GAP_LOAD  = GAP_W'(CMD_GAP - 1);
    localparam logic [IP_ADDR_W-1:0] ADDR_STEP = IP_ADDR_W'(NATIVE_BURST);
    localparam logic [BEAT_W-1:0]    LAST_BEAT = BEAT_W'(NATIVE_BURST - 1);

    psram_state_e         state_q, state_d;
    logic                 dir_q, dir_d;
    logic [IP_ADDR_W-1:0] addr_q, addr_d;
    logic [10:0]          rem_q, rem_d;
    logic [BEAT_W-1:0]    beat_q, beat_d;
    logic                 calib_q;

    logic        ready_w;
    logic        gap_load;
    logic        gap_zero;
    logic [11:0] rem_ext;
    logic [11:0] chunk;
    logic        word_real;
    logic        unused_addr_hi;

    // Upper request address bits lie outside the IP word space.
    assign unused_addr_hi = ^xMemAddress[31:IP_ADDR_W];

    assign rem_ext   = {1'b0, rem_q};
    assign chunk     = (rem_ext < NB12) ? rem_ext : NB12;
    assign word_real = (12'(beat_q) < rem_ext);
    assign ready_w   = (state_q == ST_IDLE) && calib_q;
    assign xDbgState = state_q;

    psram_cmd_gap_timer #(
        .WIDTH (GAP_W)
    ) u_gap_timer (
        .clk_i      (xClk),
        .rst_ni     (xResetN),
        .load_i     (gap_load),
        .load_val_i (GAP_LOAD),
        .zero_o     (gap_zero)
    );

    // Handshakes: a request is taken in the cycle it meets xPsramReady high;
    // xWrReady pops the show-ahead FIFO head in the cycle it is high;
    // xRdValid marks xRdData for exactly one cycle with no backpressure.
    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        beat_d      = beat_q;
        gap_load    = 1'b0;
        xPsramReady = ready_w;
        xPsramDone  = 1'b0;
        xWrReady    = 1'b0;
        xRdValid    = 1'b0;
        xRdData     = '0;
        xIpCmdEn    = 1'b0;
        xIpCmd      = 1'b0;
        xIpAddr     = '0;
        xIpWrData   = '0;
        xIpDataMask = 4'h0;

        case (state_q)
            ST_IDLE: begin
                if (ready_w && (xPsramReqRead || xPsramReqWrite)) begin
                    dir_d   = xPsramReqWrite ? PSRAM_CMD_WR : PSRAM_CMD_RD;
                    addr_d  = xMemAddress[IP_ADDR_W-1:0];
                    rem_d   = xBurstLength;
                    beat_d  = '0;
                    state_d = (xBurstLength == '0) ? ST_DONE : ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (gap_zero && ((dir_q == PSRAM_CMD_RD) || (xWrCount >= chunk))) begin
                    state_d = ST_CMD;
                end
            end

            ST_CMD: begin
                xIpCmdEn = 1'b1;
                xIpCmd   = dir_q;
                xIpAddr  = addr_q;
                gap_load = 1'b1;
                if (dir_q == PSRAM_CMD_WR) begin
                    xIpWrData   = xWrData;
                    xWrReady    = word_real;
                    xIpDataMask = word_real ? 4'h0 : 4'hF;
                    beat_d      = beat_q + 1'b1;
                    state_d     = (beat_q == LAST_BEAT) ? ST_NEXT : ST_WDATA;
                end else begin
                    beat_d  = '0;
                    state_d = ST_RWAIT;
                end
            end

            ST_WDATA: begin
                xIpWrData   = xWrData;
                xWrReady    = word_real;
                xIpDataMask = word_real ? 4'h0 : 4'hF;
                beat_d      = beat_q + 1'b1;
                if (beat_q == LAST_BEAT) begin
                    state_d = ST_NEXT;
                end
            end

            ST_RWAIT: begin
                if (xIpRdValid) begin
                    xRdValid = word_real;
                    xRdData  = word_real ? xIpRdData : '0;
                    beat_d   = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        state_d = ST_NEXT;
                    end
                end
            end

            ST_NEXT: begin
                rem_d   = rem_q - chunk[10:0];
                addr_d  = addr_q + ADDR_STEP;
                beat_d  = '0;
                state_d = (rem_q == chunk[10:0]) ? ST_DONE : ST_WAIT;
            end

            ST_DONE: begin
                xPsramDone = 1'b1;
                state_d    = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge xClk or negedge xResetN) begin
        if (!xResetN) begin
            state_q <= ST_IDLE;
            dir_q   <= PSRAM_CMD_RD;
            addr_q  <= '0;
            rem_q   <= '0;
            beat_q  <= '0;
            calib_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            beat_q  <= beat_d;
            calib_q <= xIpCalibDone;
        end
    end

endmodule

// File: doc/psram_burst_ctrl.md
# psram_burst_ctrl

- Responder end of the PSRAM request interface.
- Accepts one read or write burst request (`xPsramReqRead`/`xPsramReqWrite`, `xMemAddress`, `xBurstLength`) from the port arbiter.
- Splits the burst into fixed-size native commands for the PSRAM IP and streams data between the IP and the MCU write FIFO / emulation read path.
- Reports completion with `xPsramDone` and readiness with `xPsramReady`.

## Interface
Parameters:
- `NATIVE_BURST`, 16 — words per IP command; power of two.
- `CMD_GAP`, 20 — minimum cycles between consecutive `xIpCmdEn` pulses.
- `IP_ADDR_W`, 21 — IP word-address width.

Ports (name, direction, width, meaning):
- `xClk` in 1 — single clock.
- `xResetN` in 1 — asynchronous, active-low reset.
- `xPsramReqRead` in 1 — read request.
- `xPsramReqWrite` in 1 — write request.
- `xMemAddress` in 32 — word address.
- `xBurstLength` in 11 — burst length in words.
- `xPsramReady` out 1 — high in IDLE when `xIpCalibDone` is high.
- `xPsramDone` out 1 — one-cycle completion pulse.
- `xWrData` in 32 — write word from the show-ahead FIFO head.
- `xWrCount` in 12 — FIFO fill level.
- `xWrReady` out 1 — FIFO pop.
- `xRdData` out 32 — read word; no backpressure.
- `xRdValid` out 1 — read word valid; no backpressure.
- `xIpCmdEn` out 1 — IP command strobe.
- `xIpCmd` out 1 — IP command: 1 = write, 0 = read.
- `xIpAddr` out IP_ADDR_W — IP command address.
- `xIpWrData` out 32 — IP write data.
- `xIpDataMask` out 4 — IP byte mask; 1 = byte masked.
- `xIpRdData` in 32 — IP read data.
- `xIpRdValid` in 1 — IP read data valid.
- `xIpCalibDone` in 1 — IP calibration complete.

## Operation
States:
- **IDLE** — `xPsramReady` = `xIpCalibDone`.
  - Accepts a request when ready.
  - If read and write requests arrive together, write wins and the read is dropped.
  - Latches direction, address and remaining count (`rem` = `xBurstLength`).
  - Goes to DONE if `xBurstLength` = 0, else to WAIT.
  - Requests in any other state are ignored.
- **WAIT** — goes to CMD when both hold:
  - the gap counter is 0;
  - for writes, `xWrCount` ≥ min(`rem`, NATIVE_BURST).
- **CMD** — drives the command:
  - `xIpCmdEn`=1, `xIpCmd` = direction, `xIpAddr` = current address.
  - For writes, word 0 is presented this cycle.
  - Loads the gap counter with CMD_GAP-1.
  - Next state: writes → WDATA; reads → RWAIT.
- **WDATA** — presents words 1..NATIVE_BURST-1 on consecutive cycles, then goes to NEXT.
- **Write words, index i** (applies in CMD and WDATA):
  - `xIpWrData` = `xWrData`.
  - For i < `rem`: `xWrReady`=1 and `xIpDataMask`=0.
  - Otherwise: `xWrReady`=0, `xIpDataMask`=4'hF (pad word).
- **RWAIT** — counts NATIVE_BURST `xIpRdValid` beats.
  - Beats with index < `rem` are forwarded as `xRdData`/`xRdValid`; the rest are discarded.
  - After the last beat → NEXT.
- **NEXT** — `rem` -= min(`rem`, NATIVE_BURST); address += NATIVE_BURST, modulo 2^IP_ADDR_W. Then → DONE if `rem`=0, else → WAIT.
- **DONE** — `xPsramDone`=1 for one cycle, then → IDLE.

Other rules:
- `xIpRdValid` outside RWAIT is ignored.
- The gap counter decrements independently of state and saturates at 0.
- Reset mid-operation: every state and counter clears immediately. A burst in flight is abandoned with no done pulse, and IP read data arriving later is ignored.

## Timing
- Reset values: every output 0, including `xPsramReady` until the first clock with `xIpCalibDone` high; state IDLE; gap counter 0.
- Accept at cycle t → WAIT at t+1 → earliest `xIpCmdEn` at t+2.
- `xPsramReady` falls at t+1 and stays low through DONE.
- Consecutive `xIpCmdEn` pulses are ≥ CMD_GAP cycles apart, including across separate requests.
- Write chunk: NATIVE_BURST contiguous cycles starting with CMD; NEXT is one cycle; DONE is one cycle.
- `xRdValid` appears in the same cycle as the corresponding `xIpRdValid`; `xRdData` = `xIpRdData`, combinational pass-through.
- Length-0 request: done pulse at t+1, no IP command.

## Structure
- Package `psram_pkg`:
  - state enum;
  - `NATIVE_BURST` and `CMD_GAP` defaults;
  - direction constants `PSRAM_CMD_RD`=0, `PSRAM_CMD_WR`=1.
- Sub-module `psram_cmd_gap_timer`: loadable down-counter, saturates at 0, outputs zero flag.
- The FSM and the beat/`rem` counters stay in `psram_burst_ctrl`.

## Test plan
- Write, len 16, addr 0x100, `xWrCount`=16:
  - one `xIpCmdEn`, cmd=1, addr 0x100;
  - 16 consecutive words, all mask 0;
  - 16 `xWrReady` pulses;
  - one `xPsramDone`.
- Write, len 20:
  - commands at 0x100 and 0x110, ≥20 cycles apart;
  - second chunk is 4 real words, then 12 words with mask F;
  - 20 pops total.
- Read, len 5, addr 0x40; IP returns 16 words D0..D15:
  - `xRdValid` pulses 5 times with D0..D4;
  - done pulse after D15.
- Simultaneous read and write requests → only the write is served; `xPsramReady` stays low until after done.
- Write, len 16, `xWrCount`=3 → no `xIpCmdEn` until `xWrCount` reaches 16.
- Length 0 → done at t+1 with no command.
- `xResetN` low after 8 read beats → all outputs 0; remaining beats produce no `xRdValid`; ready returns high with calib.
